// File: rtl/phase_shift_gen_pkg.sv
// Shared constants, control-state encoding and sine-table generator for phase_shift_gen.
package phase_shift_gen_pkg;

  localparam int N_SAMP   = 32;
  localparam int DEG_FULL = 360;
  localparam int DIV_STEP = 45;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CALC = 2'd2,
    PEND = 2'd3
  } state_t;

  localparam real PI = 3.14159265358979323846;

  // Elaboration-time only: round(A*sin(2*pi*k/N_SAMP)) with A = 2^(m-1)-1, rounded half away from zero.
  function automatic int sine_sample(input int k, input int m);
    real amp;
    real v;
    amp = real'((1 << (m - 1)) - 1);
    v   = amp * $sin(2.0 * PI * real'(k) / real'(N_SAMP));
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

endpackage

// File: rtl/phase_shift_gen_delay.sv
// Serial divider: delay = floor(4*phase/45), one subtraction per clock, done after delay+1 clocks.
module phase_to_delay
  import phase_shift_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] phase,
  output logic        done,
  output logic [4:0]  delay
);

  logic [17:0] rem;
  logic        active;

  // The caller only starts with phase <= 359, so the quotient always fits in 5 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem    <= '0;
      delay  <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem    <= {phase, 2'b00};
        delay  <= '0;
        active <= 1'b1;
      end else if (active) begin
        if (rem >= 18'(DIV_STEP)) begin
          rem   <= rem - 18'(DIV_STEP);
          delay <= delay + 5'd1;
        end else begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/phase_shift_gen.sv
// Reference sinusoid plus a copy lagging by a programmable number of samples;
// a new lag is computed off-line and only swapped in at a period boundary.
module phase_shift_gen
  import phase_shift_gen_pkg::*;
#(
  parameter int M = 14,
  parameter int N = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [15:0]         phase_in,
  input  logic                phase_load,
  output logic                phase_busy,
  output logic                phase_ack,
  output logic                phase_err,
  output logic                period_start,
  output logic signed [M-1:0] Vref,
  output logic signed [M-1:0] Vout
);

  logic signed [M-1:0] sine_tab [N];

  for (genvar k = 0; k < N; k++) begin : g_tab
    assign sine_tab[k] = M'(sine_sample(k, M));
  end

  state_t     state, state_next;
  logic [4:0] idx;
  logic [4:0] delay_q;
  logic [4:0] vout_idx;
  logic [4:0] div_delay;
  logic       div_start;
  logic       div_done;
  logic       wrap;
  logic       err_set;
  logic       apply;

  assign wrap     = en && (idx == 5'(N - 1));
  assign vout_idx = idx - delay_q;

  phase_to_delay u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .phase (phase_in),
    .done  (div_done),
    .delay (div_delay)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Loads are only looked at in RUN, so a request while busy is silently dropped.
  always_comb begin
    state_next = state;
    div_start  = 1'b0;
    err_set    = 1'b0;
    apply      = 1'b0;
    case (state)
      IDLE: state_next = RUN;
      RUN: begin
        if (phase_load) begin
          if (phase_in < 16'(DEG_FULL)) begin
            div_start  = 1'b1;
            state_next = CALC;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      CALC: if (div_done) state_next = PEND;
      PEND: begin
        if (wrap) begin
          apply      = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      delay_q    <= '0;
      phase_busy <= 1'b0;
      phase_ack  <= 1'b0;
      phase_err  <= 1'b0;
    end else begin
      phase_ack <= apply;
      phase_err <= err_set;
      if (div_start)  phase_busy <= 1'b1;
      else if (apply) phase_busy <= 1'b0;
      if (apply) delay_q <= div_delay;
    end
  end

  // The wrap edge still registers sample 31 with the old lag; the new lag starts at sample 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx          <= '0;
      Vref         <= '0;
      Vout         <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= 1'b0;
      if (en) begin
        idx          <= idx + 5'd1;
        Vref         <= sine_tab[idx];
        Vout         <= sine_tab[vout_idx];
        period_start <= (idx == 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_phase_shift_gen.sv
// Randomised scoreboard bench for phase_shift_gen against a sample-level reference model.
module tb_phase_shift_gen;

  localparam int M = 14;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic [15:0]         phase_in;
  logic                phase_load;
  logic                phase_busy;
  logic                phase_ack;
  logic                phase_err;
  logic                period_start;
  logic signed [M-1:0] Vref;
  logic signed [M-1:0] Vout;

  phase_shift_gen #(.M(M), .N(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .phase_in     (phase_in),
    .phase_load   (phase_load),
    .phase_busy   (phase_busy),
    .phase_ack    (phase_ack),
    .phase_err    (phase_err),
    .period_start (period_start),
    .Vref         (Vref),
    .Vout         (Vout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [M-1:0] vref;
    logic signed [M-1:0] vout;
    logic                pstart;
    logic                ack;
    logic                busy;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   ref_sine[32];
  int   m_idx;
  int   m_delay;
  int   m_pend_delay;
  bit   m_has_pend;

  function automatic int ref_sample(input int k);
    real v;
    v = 8191.0 * $sin(2.0 * 3.14159265358979323846 * k / 32.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Model of one enabled sample clock: what the DUT must present just after that edge.
  task automatic model_edge();
    exp_t e;
    e.vref   = M'(ref_sine[m_idx]);
    e.vout   = M'(ref_sine[(m_idx - m_delay + 32) % 32]);
    e.pstart = (m_idx == 0);
    e.ack    = (m_idx == 31) && m_has_pend;
    if (e.ack) begin
      m_delay    = m_pend_delay;
      m_has_pend = 1'b0;
    end
    e.busy = m_has_pend;
    sb.push_back(e);
    m_idx = (m_idx + 1) % 32;
  endtask

  task automatic apply_stimulus(input bit e);
    @(negedge clk);
    en = e;
    if (e) model_edge();
  endtask

  task automatic run_random(input int n);
    repeat (n) apply_stimulus($urandom_range(0, 3) != 0);
  endtask

  // Load with en held low long enough for the divider to finish before the next wrap.
  task automatic do_load(input int p);
    bit ignored;
    bit legal;
    @(negedge clk);
    en         = 1'b0;
    phase_load = 1'b1;
    phase_in   = 16'(p);
    ignored    = m_has_pend;
    legal      = (p < 360);
    @(negedge clk);
    phase_load = 1'b0;
    check_output("busy_after_load", 32'(phase_busy), 32'(ignored || legal));
    check_output("err_pulse", 32'(phase_err), 32'(!ignored && !legal));
    if (!ignored && legal) begin
      m_has_pend   = 1'b1;
      m_pend_delay = (p * 32) / 360;
    end
    @(negedge clk);
    check_output("err_clear", 32'(phase_err), 32'd0);
    repeat (40) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst && en) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_underflow: got a sample expected none");
        end else begin
          e = sb.pop_front();
          if (Vref !== e.vref || Vout !== e.vout || period_start !== e.pstart ||
              phase_ack !== e.ack || phase_busy !== e.busy) begin
            errors++;
            $display("[TB] FAIL sample: got vref=%0d vout=%0d ps=%0b ack=%0b busy=%0b expected vref=%0d vout=%0d ps=%0b ack=%0b busy=%0b",
                     Vref, Vout, period_start, phase_ack, phase_busy,
                     e.vref, e.vout, e.pstart, e.ack, e.busy);
          end
        end
      end
    end
  end

  initial begin
    int phases[7] = '{90, 100, 359, 0, 45, 180, 270};
    rst        = 1'b0;
    en         = 1'b0;
    phase_load = 1'b0;
    phase_in   = '0;
    for (int k = 0; k < 32; k++) ref_sine[k] = ref_sample(k);
    m_idx = 0; m_delay = 0; m_pend_delay = 0; m_has_pend = 1'b0;

    repeat (3) @(negedge clk);
    check_output("reset_vref", 32'(Vref), 32'd0);
    check_output("reset_vout", 32'(Vout), 32'd0);
    check_output("reset_flags", {28'd0, phase_busy, phase_ack, phase_err, period_start}, 32'd0);
    rst = 1'b1;

    repeat (70) apply_stimulus(1'b1);
    run_random(40);

    foreach (phases[i]) begin
      do_load(phases[i]);
      run_random(120);
    end

    do_load(360);
    run_random(40);
    do_load(1000);
    run_random(40);

    do_load(90);
    do_load(200);
    run_random(120);

    @(negedge clk);
    en         = 1'b0;
    phase_load = 1'b1;
    phase_in   = 16'd180;
    @(negedge clk);
    phase_load = 1'b0;
    check_output("busy_before_reset", 32'(phase_busy), 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("midcalc_reset_vref", 32'(Vref), 32'd0);
    check_output("midcalc_reset_vout", 32'(Vout), 32'd0);
    check_output("midcalc_reset_flags", {28'd0, phase_busy, phase_ack, phase_err, period_start}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    m_idx = 0; m_delay = 0; m_has_pend = 1'b0;
    sb.delete();
    run_random(100);

    repeat (3) apply_stimulus(1'b0);
    check_output("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phase_shift_gen.md
# phase_shift_gen

Test-signal source for the sequence decomposer. Produces a reference sinusoid `Vref` and a phase-delayed copy `Vout`, one sample per enabled clock, 32 samples per period. The delay comes from a programmable phase angle in degrees. It is the transmit-side counterpart of the zero-crossing phase measurement: feeding `Vref`/`Vout` into the measurement path must return the programmed angle, quantised to 11.25°.

## Interface
Parameters:
- `M`, 14: sample width (signed two's complement)
- `N`, 32: samples per period (fixed; power of two, 5-bit index)

Ports:
- `clk`  in  1  sole clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `en`  in  1  sample strobe; index advances only when high
- `phase_in`  in  16  requested lag in degrees, unsigned, legal 0..359
- `phase_load`  in  1  one-cycle request to latch `phase_in`
- `phase_busy`  out  1  high from accepted load until new delay applied
- `phase_ack`  out  1  one-cycle pulse when new delay takes effect
- `phase_err`  out  1  one-cycle pulse when a load is rejected
- `period_start`  out  1  one-cycle pulse coincident with `Vref` sample index 0
- `Vref`  out  M  signed reference sample
- `Vout`  out  M  signed delayed sample

## Operation
- Sine table: `S[k] = round(A*sin(2πk/32))`, A = 2^(M-1)-1, k = 0..31.
  - S[0] = S[16] = 0; S[1..15] > 0; S[17..31] < 0.
- Index counter `idx`, 5 bits, wraps 31→0, increments when `en`=1.
- `Vref = S[idx]`.
- `Vout = S[(idx - delay) mod 32]`, unsigned 5-bit subtraction wrap.
- Delay from phase: `delay = floor(phase*32/360) = floor(4*phase/45)`, range 0..31.
- Control FSM:
  - IDLE: entered on reset; moves to RUN on the next clock.
  - RUN: `phase_load` with `phase_in` ≤ 359 latches the value, sets `phase_busy`, and goes to CALC. With `phase_in` ≥ 360, it pulses `phase_err`, stays in RUN, and keeps the old delay.
  - CALC: serial divider computes `delay_new`. Then go to PEND.
  - PEND: wait for the `idx` 31→0 wrap, when `en`=1. On that edge: `delay <= delay_new`, pulse `phase_ack`, clear `phase_busy`, return to RUN.
- `phase_load` while `phase_busy`=1 is ignored, with no `phase_err`.
- `en`=0 freezes `idx` and the outputs. CALC still progresses, and PEND waits.
- Reset mid-CALC or mid-PEND: the pending phase is discarded and `delay` returns to 0.

## Timing
- Reset values: `Vref`=0, `Vout`=0, `idx`=0, `delay`=0, `phase_busy`=0, `phase_ack`=0, `phase_err`=0, `period_start`=0, FSM=IDLE.
- Outputs are registered: the sample for `idx`=k appears one clock after the `en` edge that selects k.
- `period_start` is aligned with `Vref`=S[0].
- CALC timing:
  - Dividend `4*phase` (≤1436) is reduced by repeated subtraction of 45, counting iterations.
  - Latency is `delay_new`+1 clocks; maximum 32 clocks.
  - Worst-case load-to-ack is 32 + 32 sample periods.
- `phase_ack` is asserted in the same cycle the first sample using the new delay is registered.
- Simultaneous `phase_load` and wrap in RUN: the wrap uses the old delay, and the load proceeds to CALC normally.
- The negative-going zero crossing of `Vref` is S[16]→S[17]. `Vout`'s crossing follows it by exactly `delay` samples.

## Structure
- Shared package constants:
  - `N_SAMP`=32
  - `DEG_FULL`=360
  - `DIV_STEP`=45
  - FSM state encoding (IDLE/RUN/CALC/PEND, 2-bit)
  - Sine table as a constant function of M
- One sub-module, `phase_to_delay`: serial subtract divider.
  - Inputs: `start`, `phase[15:0]`.
  - Outputs: `done` pulse, `delay[4:0]`.
  - Owns the CALC latency.
- Top level holds `idx`, the FSM, the two table lookups and the output registers.

## Test plan
- Reset released, `en`=1 held, no load → `Vref`=`Vout`=S[idx` each sample; `period_start` every 32 clocks; first pulse 1 clock after first `en` edge.
- Load `phase_in`=90 → `phase_busy` until next wrap, then `phase_ack`; thereafter `delay`=8, `Vout`[t] = `Vref`[t-8].
- Load `phase_in`=100 → `delay`=8 (floor 8.89); load 359 → `delay`=31; load 0 → `delay`=0.
- Load `phase_in`=360 → single `phase_err` pulse, `delay` unchanged, `phase_busy` stays 0; second load during `phase_busy` → ignored.
- Assert `rst` low during CALC for `phase_in`=180 → all outputs 0 immediately; after release, `delay`=0 and no `phase_ack`.
- Loopback into the phase measurement block for phase 0, 45, 90, 180, 270 → measured phase equals `delay*360/32`, i.e. 0, 45, 90, 180, 270.
